mega_alu_arb: RTL and testbench

- Two-port arbiter/sequencer that shares one combinational MEGA/XMEGA ALU between the core execute stage (port 0) and a secondary requester such as a debug unit or coprocessor (port 1).
- Accepts requests with a valid/ready handshake and drives the ALU operand bus.
- Returns a registered result plus SREG one cycle after acceptance.
- Supports locked multi-operation sequences (e.g. SUB then SBC carry chains) so the other port cannot interleave.

---
 rtl/mega_alu_arb_if.sv | 40 ++++
 rtl/mega_alu_arb.sv | 136 +++++++++++++
 tb/tb_mega_alu_arb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mega_alu_arb_if.sv
// mega_alu_arb_if: request, ALU-drive and response bundle for mega_alu_arb.
//   req_*      : two-port request side (valid/ready/lock, per-port operands)
//   alu_*      : operand bus to the shared combinational ALU, and its result
//   rsp_*      : registered one-cycle response, lock_abort timeout pulse
// Modports: slave = arbiter, master = environment (requesters + ALU).
interface mega_alu_arb_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_lock;
   logic [15:0] req_inst0, req_inst1;
   logic [4:0]  req_rda0, req_rda1, req_rra0, req_rra1;
   logic [15:0] req_rd0, req_rd1, req_rr0, req_rr1;
   logic [7:0]  req_sreg0, req_sreg1;
   logic [15:0] alu_inst;
   logic [4:0]  alu_rda, alu_rra;
   logic [15:0] alu_rd, alu_rr;
   logic [7:0]  alu_sreg_in;
   logic [15:0] alu_R;
   logic [7:0]  alu_sreg;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_R;
   logic [7:0]  rsp_sreg;
   logic        lock_abort;

   modport slave (
      input  req_valid, req_lock, req_inst0, req_inst1, req_rda0, req_rda1,
             req_rra0, req_rra1, req_rd0, req_rd1, req_rr0, req_rr1,
             req_sreg0, req_sreg1, alu_R, alu_sreg,
      output req_ready, alu_inst, alu_rda, alu_rra, alu_rd, alu_rr,
             alu_sreg_in, rsp_valid, rsp_R, rsp_sreg, lock_abort
   );

   modport master (
      output req_valid, req_lock, req_inst0, req_inst1, req_rda0, req_rda1,
             req_rra0, req_rra1, req_rd0, req_rd1, req_rr0, req_rr1,
             req_sreg0, req_sreg1, alu_R, alu_sreg,
      input  req_ready, alu_inst, alu_rda, alu_rra, alu_rd, alu_rr,
             alu_sreg_in, rsp_valid, rsp_R, rsp_sreg, lock_abort
   );
endinterface

// File: rtl/mega_alu_arb.sv
// mega_alu_arb: two-port arbiter sharing one combinational MEGA/XMEGA ALU
// between the execute stage (port 0) and a secondary requester (port 1).
//   clk, rst : core clock, async active-high reset
//   bus      : mega_alu_arb_if.slave (requests, ALU drive bus, responses)
// Accepted op drives the ALU the same cycle; result/SREG registered and
// pulsed on rsp_valid[n] the next cycle. req_lock keeps ownership across a
// multi-op chain; an owner idle for LOCK_MAX cycles is dropped (lock_abort).
// Optional: define MEGA_ALU_ARB_STARVE_EN to force a port-1 grant after
// STARVE_LIMIT consecutive denied cycles (idle arbitration only).
module mega_alu_arb #(
   parameter int RR_MODE      = 0,
   parameter int LOCK_MAX     = 15,
   parameter int STARVE_LIMIT = 8
) (
   input logic           clk,
   input logic           rst,
   mega_alu_arb_if.slave bus
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OWN0 = 2'b01;
   localparam logic [1:0] OWN1 = 2'b10;

   logic [1:0] state;
   logic       last_grant;
   logic [7:0] idle_cnt;
   logic [1:0] ready;
   logic       owned, owner, timeout, starve_win;

   assign owned   = (state == OWN0) || (state == OWN1);
   assign owner   = (state == OWN1);
   // The timeout cycle still arbitrates under owner rules; release is at its end.
   assign timeout = owned && (idle_cnt == 8'(LOCK_MAX));

`ifdef MEGA_ALU_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   // Saturates so a long lock cannot wrap it back below the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else if (!bus.req_valid[1] || ready[1])
         starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
         starve_cnt <= starve_cnt + SW'(1);
   end
   assign starve_win = (starve_cnt == SW'(STARVE_LIMIT));
`else
   // Starvation override compiled out; the parameter only keeps one shared
   // parameter list for both builds.
   assign starve_win = 1'b0 & (STARVE_LIMIT != 0);
`endif

   // Ready is gated by valid, so ready itself is the acceptance vector.
   always_comb begin
      ready = 2'b00;
      case (state)
         OWN0:    ready[0] = bus.req_valid[0];
         OWN1:    ready[1] = bus.req_valid[1];
         default: begin
            if (bus.req_valid == 2'b11) begin
               if (starve_win)        ready = 2'b10;
               else if (RR_MODE != 0) ready = last_grant ? 2'b01 : 2'b10;
               else                   ready = 2'b01;
            end else begin
               ready = bus.req_valid;
            end
         end
      endcase
   end

   assign bus.req_ready  = ready;
   assign bus.lock_abort = timeout;

   // ALU operand mux; NOP with zeroed fields when nothing is accepted.
   always_comb begin
      bus.alu_inst    = 16'h0000;
      bus.alu_rda     = 5'd0;
      bus.alu_rra     = 5'd0;
      bus.alu_rd      = 16'h0000;
      bus.alu_rr      = 16'h0000;
      bus.alu_sreg_in = 8'h00;
      if (ready[0]) begin
         bus.alu_inst    = bus.req_inst0;
         bus.alu_rda     = bus.req_rda0;
         bus.alu_rra     = bus.req_rra0;
         bus.alu_rd      = bus.req_rd0;
         bus.alu_rr      = bus.req_rr0;
         bus.alu_sreg_in = bus.req_sreg0;
      end else if (ready[1]) begin
         bus.alu_inst    = bus.req_inst1;
         bus.alu_rda     = bus.req_rda1;
         bus.alu_rra     = bus.req_rra1;
         bus.alu_rd      = bus.req_rd1;
         bus.alu_rr      = bus.req_rr1;
         bus.alu_sreg_in = bus.req_sreg1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         idle_cnt      <= 8'd0;
         bus.rsp_valid <= 2'b00;
         bus.rsp_R     <= 16'h0000;
         bus.rsp_sreg  <= 8'h00;
      end else begin
         bus.rsp_valid <= ready;
         if (|ready) begin
            bus.rsp_R    <= bus.alu_R;
            bus.rsp_sreg <= bus.alu_sreg;
            last_grant   <= ready[1];
         end
         case (state)
            OWN0, OWN1: begin
               if (timeout) begin
                  state    <= IDLE;
                  idle_cnt <= 8'd0;
               end else if (ready[owner]) begin
                  idle_cnt <= 8'd0;
                  if (!bus.req_lock[owner]) state <= IDLE;
               end else if (!bus.req_valid[owner]) begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
            default: begin
               state    <= IDLE;
               idle_cnt <= 8'd0;
               if (ready[0] && bus.req_lock[0])      state <= OWN0;
               else if (ready[1] && bus.req_lock[1]) state <= OWN1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mega_alu_arb.sv
// tb_mega_alu_arb: scoreboard bench for mega_alu_arb. Two instances share the
// same stimulus: dut_a fixed priority, dut_b round-robin, both LOCK_MAX=3.
// A small AVR ALU model (ADD/SUB/SBC) answers each instance's ALU bus.
module tb_mega_alu_arb;
   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] rd;
      logic [15:0] rr;
      logic [7:0]  sreg;
   } op_t;

   typedef struct packed {
      logic [1:0]  port;
      logic [15:0] r;
      logic [7:0]  sreg;
   } exp_t;

   localparam op_t ZERO = '{16'h0000, 16'h0000, 16'h0000, 8'h00};
   localparam op_t ADD1 = '{16'h0C01, 16'h000F, 16'h0001, 8'h00};
   localparam op_t A0   = '{16'h0C01, 16'h0001, 16'h0002, 8'h00};
   localparam op_t B1   = '{16'h0C01, 16'h0080, 16'h0080, 8'h00};
   localparam op_t SUB0 = '{16'h1801, 16'h0000, 16'h0001, 8'h00};
   localparam op_t SBC0 = '{16'h0801, 16'h0000, 16'h0000, 8'h01};

   // Hand-computed responses
   localparam exp_t R_ADD1 = '{2'b01, 16'h0010, 8'h20};  // H only
   localparam exp_t R_A0   = '{2'b01, 16'h0003, 8'h00};
   localparam exp_t R_B1   = '{2'b10, 16'h0000, 8'h1B};  // C Z V S
   localparam exp_t R_SUB  = '{2'b01, 16'h00FF, 8'h35};  // C N S H
   localparam exp_t R_SBC  = '{2'b01, 16'h00FF, 8'h35};

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic [1:0] ra, rb;

   always #5 clk = ~clk;

   mega_alu_arb_if ifa ();
   mega_alu_arb_if ifb ();

   mega_alu_arb #(.RR_MODE(0), .LOCK_MAX(3), .STARVE_LIMIT(8)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa));
   mega_alu_arb #(.RR_MODE(1), .LOCK_MAX(3), .STARVE_LIMIT(8)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb));

   function automatic logic [23:0] alu(input logic [15:0] inst, input logic [15:0] rd,
                                       input logic [15:0] rr, input logic [7:0] s);
      logic [7:0] a, b, r, so;
      logic c, z, n, v, h;
      a = rd[7:0]; b = rr[7:0]; so = s; r = 8'h00;
      c = 1'b0; z = 1'b0; v = 1'b0; h = 1'b0;
      case (inst[15:10])
         6'b000011: begin
            r = a + b;
            h = (a[3] & b[3]) | (b[3] & ~r[3]) | (~r[3] & a[3]);
            c = (a[7] & b[7]) | (b[7] & ~r[7]) | (~r[7] & a[7]);
            v = (a[7] & b[7] & ~r[7]) | (~a[7] & ~b[7] & r[7]);
            z = (r == 8'h00);
         end
         6'b000110, 6'b000010: begin
            r = a - b - ((inst[15:10] == 6'b000010) ? {7'd0, s[0]} : 8'h00);
            h = (~a[3] & b[3]) | (b[3] & r[3]) | (r[3] & ~a[3]);
            c = (~a[7] & b[7]) | (b[7] & r[7]) | (r[7] & ~a[7]);
            v = (a[7] & ~b[7] & ~r[7]) | (~a[7] & b[7] & r[7]);
            z = (r == 8'h00) & ((inst[15:10] == 6'b000010) ? s[1] : 1'b1);
         end
         default: return {16'h0000, s};
      endcase
      n = r[7];
      so[0] = c; so[1] = z; so[2] = n; so[3] = v; so[4] = n ^ v; so[5] = h;
      return {8'h00, r, so};
   endfunction

   always_comb {ifa.alu_R, ifa.alu_sreg} = alu(ifa.alu_inst, ifa.alu_rd, ifa.alu_rr, ifa.alu_sreg_in);
   always_comb {ifb.alu_R, ifb.alu_sreg} = alu(ifb.alu_inst, ifb.alu_rd, ifb.alu_rr, ifb.alu_sreg_in);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] lk, input op_t p0, input op_t p1);
      ifa.req_valid = v;  ifb.req_valid = v;
      ifa.req_lock  = lk; ifb.req_lock  = lk;
      ifa.req_inst0 = p0.inst; ifb.req_inst0 = p0.inst;
      ifa.req_rd0   = p0.rd;   ifb.req_rd0   = p0.rd;
      ifa.req_rr0   = p0.rr;   ifb.req_rr0   = p0.rr;
      ifa.req_sreg0 = p0.sreg; ifb.req_sreg0 = p0.sreg;
      ifa.req_inst1 = p1.inst; ifb.req_inst1 = p1.inst;
      ifa.req_rd1   = p1.rd;   ifb.req_rd1   = p1.rd;
      ifa.req_rr1   = p1.rr;   ifb.req_rr1   = p1.rr;
      ifa.req_sreg1 = p1.sreg; ifb.req_sreg1 = p1.sreg;
   endtask

   task automatic chk_rdy(input string nm, input logic [1:0] xa, input logic [1:0] xb);
      chk({nm, "_ready_a"}, ifa.req_ready, xa);
      chk({nm, "_ready_b"}, ifb.req_ready, xb);
   endtask

   // Monitors: pop one expectation per response pulse.
   always @(negedge clk) begin
      if (ifa.rsp_valid != 2'b00) begin
         if (qa.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL a_unexpected_rsp: got valid %b expected none", ifa.rsp_valid);
         end else begin
            ea = qa.pop_front();
            chk("a_rsp_valid", ifa.rsp_valid, ea.port);
            chk("a_rsp_R", ifa.rsp_R, ea.r);
            chk("a_rsp_sreg", ifa.rsp_sreg, ea.sreg);
         end
      end
   end

   always @(negedge clk) begin
      if (ifb.rsp_valid != 2'b00) begin
         if (qb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL b_unexpected_rsp: got valid %b expected none", ifb.rsp_valid);
         end else begin
            eb = qb.pop_front();
            chk("b_rsp_valid", ifb.rsp_valid, eb.port);
            chk("b_rsp_R", ifb.rsp_R, eb.r);
            chk("b_rsp_sreg", ifb.rsp_sreg, eb.sreg);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      ifa.req_rda0 = 5'd1; ifa.req_rra0 = 5'd2; ifa.req_rda1 = 5'd3; ifa.req_rra1 = 5'd4;
      ifb.req_rda0 = 5'd1; ifb.req_rra0 = 5'd2; ifb.req_rda1 = 5'd3; ifb.req_rra1 = 5'd4;
      drive(2'b00, 2'b00, ZERO, ZERO);
      #1 rst = 1'b1;
      @(negedge clk); #1;
      chk("reset_rsp_valid", ifa.rsp_valid, 2'b00);
      chk("reset_rsp_R", ifa.rsp_R, 16'h0000);
      chk("reset_rsp_sreg", ifa.rsp_sreg, 8'h00);
      chk("reset_lock_abort", ifa.lock_abort, 1'b0);
      chk("reset_alu_nop", ifa.alu_inst, 16'h0000);
      chk("reset_rsp_valid_b", ifb.rsp_valid, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      // Contention from reset: fixed priority always 0; round-robin 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'b00, A0, B1); #1;
         chk_rdy("contend", 2'b01, (i % 2 == 0) ? 2'b01 : 2'b10);
         qa.push_back(R_A0);
         qb.push_back((i % 2 == 0) ? R_A0 : R_B1);
         @(negedge clk);
      end

      // Single op, port 0 ADD 0x0F + 0x01
      drive(2'b01, 2'b00, ADD1, ZERO); #1;
      chk_rdy("single", 2'b01, 2'b01);
      chk("single_alu_inst", ifa.alu_inst, 16'h0C01);
      chk("single_alu_rda", ifa.alu_rda, 5'd1);
      chk("single_alu_rd", ifa.alu_rd, 16'h000F);
      qa.push_back(R_ADD1); qb.push_back(R_ADD1);
      @(negedge clk);
      drive(2'b00, 2'b00, ADD1, ZERO); #1;
      chk_rdy("idle", 2'b00, 2'b00);
      chk("idle_alu_nop", ifa.alu_inst, 16'h0000);
      chk("idle_alu_rd", ifa.alu_rd, 16'h0000);
      @(negedge clk); #1;
      chk("hold_rsp_R", ifa.rsp_R, 16'h0010);
      @(negedge clk);

      // Port 1 alone
      drive(2'b10, 2'b00, ZERO, B1); #1;
      chk_rdy("p1_only", 2'b10, 2'b10);
      chk("p1_alu_rda", ifa.alu_rda, 5'd3);
      qa.push_back(R_B1); qb.push_back(R_B1);
      @(negedge clk);

      // Lock chain: SUB locked, SBC unlocked, port 1 waiting throughout
      drive(2'b11, 2'b01, SUB0, B1); #1;
      chk_rdy("lock_sub", 2'b01, 2'b01);
      qa.push_back(R_SUB); qb.push_back(R_SUB);
      @(negedge clk);
      drive(2'b11, 2'b00, SBC0, B1); #1;
      chk_rdy("lock_sbc", 2'b01, 2'b01);
      qa.push_back(R_SBC); qb.push_back(R_SBC);
      @(negedge clk);
      drive(2'b10, 2'b00, ZERO, B1); #1;
      chk_rdy("after_unlock", 2'b10, 2'b10);
      qa.push_back(R_B1); qb.push_back(R_B1);
      @(negedge clk);

      // Lock timeout (LOCK_MAX=3): owner idles, abort on 4th owned cycle
      drive(2'b01, 2'b01, A0, ZERO); #1;
      chk_rdy("to_lock", 2'b01, 2'b01);
      qa.push_back(R_A0); qb.push_back(R_A0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         drive(2'b10, 2'b00, ZERO, B1); #1;
         chk_rdy("to_wait", (i == 4) ? 2'b10 : 2'b00, (i == 4) ? 2'b10 : 2'b00);
         chk("to_abort_a", ifa.lock_abort, (i == 3) ? 1'b1 : 1'b0);
         chk("to_abort_b", ifb.lock_abort, (i == 3) ? 1'b1 : 1'b0);
         if (i == 4) begin
            qa.push_back(R_B1); qb.push_back(R_B1);
         end
         @(negedge clk);
      end

      // Async reset right after a locked acceptance: response dropped
      drive(2'b11, 2'b01, A0, B1); #1;
      chk_rdy("rst_acc", 2'b01, 2'b01);
      @(posedge clk); #2;
      rst = 1'b1;
      drive(2'b10, 2'b00, ZERO, B1); #1;
      chk("rst_rsp_valid", ifa.rsp_valid, 2'b00);
      chk("rst_rsp_R", ifa.rsp_R, 16'h0000);
      chk("rst_rsp_sreg", ifa.rsp_sreg, 8'h00);
      chk_rdy("rst_idle", 2'b10, 2'b10);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b00, 2'b00, ZERO, ZERO);
      @(negedge clk);

      // Sustained contention; with the starvation option port 1 wins the 9th
      for (int i = 0; i < 10; i++) begin
         drive(2'b11, 2'b00, A0, B1); #1;
`ifdef MEGA_ALU_ARB_STARVE_EN
         ra = (i == 8) ? 2'b10 : 2'b01;
`else
         ra = 2'b01;
`endif
         rb = (i % 2 == 0) ? 2'b01 : 2'b10;
         chk_rdy("starve", ra, rb);
         qa.push_back((ra == 2'b10) ? R_B1 : R_A0);
         qb.push_back((rb == 2'b10) ? R_B1 : R_A0);
         @(negedge clk);
      end
      drive(2'b00, 2'b00, ZERO, ZERO);
      @(negedge clk);
      @(negedge clk); #1;
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
